// File: rtl/pipe_ctrl_if.sv
// Handshake, flush and status bundle between the pipeline controller and its surroundings.
// The slave side is the controller; the master side is the environment (fetch, stages, commit).
interface pipe_ctrl_if #(
    parameter int STAGES = 5,
    parameter int FSW    = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [STAGES-1:0] ready_go;
    logic              out_ready;
    logic              flush_req;
    logic [FSW-1:0]    flush_stage;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_allowin;
    logic [STAGES-1:0] stage_en;
    logic              commit;
    logic [31:0]       perf_commit;
    logic [31:0]       perf_stall;

    modport master (
        output in_valid, ready_go, out_ready, flush_req, flush_stage,
        input  in_ready, stage_valid, stage_allowin, stage_en, commit, perf_commit, perf_stall
    );

    modport slave (
        input  in_valid, ready_go, out_ready, flush_req, flush_stage,
        output in_ready, stage_valid, stage_allowin, stage_en, commit, perf_commit, perf_stall
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Valid/allowin chain for an N-stage in-order pipeline with partial flush and commit strobe.
// Optional retire/stall counters are built only when PIPE_CTRL_PERF_EN is defined.

// One stage's valid bit: killed stages clear, open stages take what upstream offers.
module pipe_ctrl_stage (
    input  logic clk,
    input  logic reset,
    input  logic allowin,
    input  logic kill,
    input  logic feed,
    output logic en,
    output logic valid
);
    logic valid_d, valid_q;

    always_comb begin
        valid_d = valid_q;
        if (kill)
            valid_d = 1'b0;
        else if (allowin)
            valid_d = feed;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) valid_q <= 1'b0;
        else       valid_q <= valid_d;
    end

    assign en    = allowin & feed;
    assign valid = valid_q;
endmodule

module pipe_ctrl #(
    parameter int STAGES = 5,
    parameter int FSW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    pipe_ctrl_if.slave  bus
);
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] allowin;
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] feed;
    logic [STAGES-1:0] en;
    logic [FSW-1:0]    k;
    logic              commit;
    logic              in_ready;

    // Out-of-range flush indices collapse onto the oldest stage.
    always_comb begin
        k = bus.flush_stage;
        if (bus.flush_stage > FSW'(STAGES-1))
            k = FSW'(STAGES-1);
        kill = '0;
        for (int i = 0; i < STAGES; i++)
            kill[i] = bus.flush_req & (FSW'(i) <= k);
    end

    always_comb begin
        logic room;
        allowin = '0;
        room    = bus.out_ready;
        for (int i = STAGES-1; i >= 0; i--) begin
            allowin[i] = ~valid[i] | (bus.ready_go[i] & room);
            room       = allowin[i];
        end
    end

    // A killed stage offers nothing downstream, which also suppresses stage_en[k+1].
    always_comb begin
        feed    = '0;
        feed[0] = bus.in_valid & ~bus.flush_req;
        for (int i = 1; i < STAGES; i++)
            feed[i] = valid[i-1] & bus.ready_go[i-1] & ~kill[i-1];
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        pipe_ctrl_stage u_stage (
            .clk     (clk),
            .reset   (reset),
            .allowin (allowin[g]),
            .kill    (kill[g]),
            .feed    (feed[g]),
            .en      (en[g]),
            .valid   (valid[g])
        );
    end

    assign in_ready = allowin[0] & ~bus.flush_req;
    assign commit   = valid[STAGES-1] & bus.ready_go[STAGES-1] & bus.out_ready & ~kill[STAGES-1];

    assign bus.in_ready      = in_ready;
    assign bus.stage_valid   = valid;
    assign bus.stage_allowin = allowin;
    assign bus.stage_en      = en;
    assign bus.commit        = commit;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_commit_d, perf_commit_q;
    logic [31:0] perf_stall_d,  perf_stall_q;

    always_comb begin
        perf_commit_d = perf_commit_q;
        perf_stall_d  = perf_stall_q;
        if (commit)
            perf_commit_d = perf_commit_q + 32'd1;
        if (bus.in_valid & ~in_ready)
            perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_commit_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_commit_q <= perf_commit_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign bus.perf_commit = perf_commit_q;
    assign bus.perf_stall  = perf_stall_q;
`else
    assign bus.perf_commit = '0;
    assign bus.perf_stall  = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against an ID-tracking pipeline model.
module tb_pipe_ctrl;
    localparam int S   = 5;
    localparam int FSW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.STAGES(S), .FSW(FSW)) bus ();

    pipe_ctrl #(.STAGES(S), .FSW(FSW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: instruction ID per stage (-1 = empty) and retire/stall totals.
    int          mid[S];
    int          seq;
    logic [31:0] m_pc, m_ps;

    logic           iv, ordy, fr;
    logic [S-1:0]   rg;
    logic [FSW-1:0] fs;

    logic [S-1:0] m_al, m_en, m_valid;
    logic         m_commit, m_in_ready;
    int           m_k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) mid[i] = -1;
        m_pc = '0;
        m_ps = '0;
    endtask

    function automatic logic killed(input int i);
        return fr && (i <= m_k);
    endfunction

    task automatic model_comb();
        logic room;
        m_k = (int'(fs) > S-1) ? S-1 : int'(fs);
        for (int i = 0; i < S; i++) m_valid[i] = (mid[i] >= 0);
        room = ordy;
        for (int i = S-1; i >= 0; i--) begin
            m_al[i] = !m_valid[i] || (rg[i] && room);
            room    = m_al[i];
        end
        m_in_ready = m_al[0] && !fr;
        m_commit   = m_valid[S-1] && rg[S-1] && ordy && !killed(S-1);
        m_en[0]    = iv && m_in_ready;
        for (int i = 1; i < S; i++)
            m_en[i] = m_al[i] && m_valid[i-1] && rg[i-1] && !killed(i-1);
    endtask

    task automatic model_update();
        int nid[S];
        for (int i = 0; i < S; i++) begin
            if (killed(i))         nid[i] = -1;
            else if (!m_al[i])     nid[i] = mid[i];
            else if (i == 0)       nid[i] = (iv && m_in_ready) ? seq : -1;
            else if (m_valid[i-1] && rg[i-1] && !killed(i-1)) nid[i] = mid[i-1];
            else                   nid[i] = -1;
        end
        if (iv && m_in_ready) seq++;
        if (m_commit) m_pc = m_pc + 32'd1;
        if (iv && !m_in_ready) m_ps = m_ps + 32'd1;
        for (int i = 0; i < S; i++) mid[i] = nid[i];
    endtask

    function automatic logic [S-1:0] model_valid();
        logic [S-1:0] v;
        for (int i = 0; i < S; i++) v[i] = (mid[i] >= 0);
        return v;
    endfunction

    task automatic compare_all();
        logic [31:0] exp_pc, exp_ps;
`ifdef PIPE_CTRL_PERF_EN
        exp_pc = m_pc;
        exp_ps = m_ps;
`else
        exp_pc = '0;
        exp_ps = '0;
`endif
        chk("stage_valid",   32'(bus.stage_valid),   32'(m_valid));
        chk("stage_allowin", 32'(bus.stage_allowin), 32'(m_al));
        chk("stage_en",      32'(bus.stage_en),      32'(m_en));
        chk("in_ready",      32'(bus.in_ready),      32'(m_in_ready));
        chk("commit",        32'(bus.commit),        32'(m_commit));
        chk("perf_commit",   bus.perf_commit,        exp_pc);
        chk("perf_stall",    bus.perf_stall,         exp_ps);
    endtask

    task automatic drive(input logic iv_i, input logic [S-1:0] rg_i, input logic or_i,
                         input logic fr_i, input logic [FSW-1:0] fs_i);
        iv = iv_i; rg = rg_i; ordy = or_i; fr = fr_i; fs = fs_i;
        bus.in_valid    = iv_i;
        bus.ready_go    = rg_i;
        bus.out_ready   = or_i;
        bus.flush_req   = fr_i;
        bus.flush_stage = fs_i;
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model, return at next posedge+1.
    task automatic step(input logic iv_i, input logic [S-1:0] rg_i, input logic or_i,
                        input logic fr_i, input logic [FSW-1:0] fs_i);
        drive(iv_i, rg_i, or_i, fr_i, fs_i);
        model_comb();
        @(negedge clk);
        compare_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0]  ps0;
        logic [S-1:0] rgv;
        logic [S-1:0] pat;
        seq = 0;
        model_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stage_valid", 32'(bus.stage_valid),   32'h0);
        chk("rst_allowin",     32'(bus.stage_allowin), 32'h1f);
        chk("rst_in_ready",    32'(bus.in_ready),      32'h1);
        chk("rst_commit",      32'(bus.commit),        32'h0);
        chk("rst_perf_commit", bus.perf_commit,        32'h0);
        chk("rst_perf_stall",  bus.perf_stall,         32'h0);
        reset = 1'b0;

        // Fill: first accept at edge 0, commit first in cycle 5.
        repeat (4) step(1'b1, '1, 1'b1, 1'b0, '0);
        chk("fill4_valid",  32'(bus.stage_valid), 32'h0f);
        chk("fill4_model",  32'(model_valid()),   32'h0f);
        chk("fill4_commit", 32'(bus.commit),      32'h0);
        step(1'b1, '1, 1'b1, 1'b0, '0);
        chk("fill5_valid",  32'(bus.stage_valid), 32'h1f);
        chk("fill5_model",  32'(model_valid()),   32'h1f);
        chk("fill5_commit", 32'(bus.commit),      32'h1);
        repeat (3) step(1'b1, '1, 1'b1, 1'b0, '0);
        chk("steady_commit", 32'(bus.commit), 32'h1);

        // Stage 2 stalls for three cycles.
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 5'b11011, 1'b1, 1'b0, '0);
            chk("stall_allowin", 32'(bus.stage_allowin[2:0]), 32'h0);
            chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
        end
        chk("stall_valid", 32'(bus.stage_valid), 32'h07);
        chk("stall_model", 32'(model_valid()),   32'h07);
        repeat (4) step(1'b1, '1, 1'b1, 1'b0, '0);

        // Flush stages 0..1 of a full pipe.
        drive(1'b1, '1, 1'b1, 1'b1, 3'd1);
        #1;
        chk("flush1_in_ready", 32'(bus.in_ready), 32'h0);
        step(1'b1, '1, 1'b1, 1'b1, 3'd1);
        chk("flush1_valid", 32'(bus.stage_valid), 32'h18);
        chk("flush1_model", 32'(model_valid()),   32'h18);
        repeat (4) step(1'b1, '1, 1'b1, 1'b0, '0);

        // Flush through the oldest stage suppresses its commit.
        drive(1'b1, '1, 1'b1, 1'b1, 3'd4);
        #1;
        chk("flush4_commit", 32'(bus.commit), 32'h0);
        step(1'b1, '1, 1'b1, 1'b1, 3'd4);
        chk("flush4_valid", 32'(bus.stage_valid), 32'h0);
        repeat (6) step(1'b1, '1, 1'b1, 1'b0, '0);

        // Downstream blocked for ten cycles.
        ps0 = bus.perf_stall;
        repeat (10) step(1'b1, '1, 1'b0, 1'b0, '0);
        chk("block_valid",    32'(bus.stage_valid), 32'h1f);
        chk("block_in_ready", 32'(bus.in_ready),    32'h0);
`ifdef PIPE_CTRL_PERF_EN
        chk("block_stall_delta", bus.perf_stall - ps0, 32'd10);
`else
        chk("block_stall_delta", bus.perf_stall - ps0, 32'd0);
`endif

        // Drain, then build 5'b10110 and reset asynchronously mid-cycle.
        repeat (6) step(1'b0, '1, 1'b1, 1'b0, '0);
        pat = 5'b01101;
        for (int c = 0; c < 5; c++) step(pat[c], '1, 1'b1, 1'b0, '0);
        chk("pre_rst_valid", 32'(bus.stage_valid), 32'h16);
        chk("pre_rst_model", 32'(model_valid()),   32'h16);
        drive(1'b0, '1, 1'b1, 1'b0, '0);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid",  32'(bus.stage_valid), 32'h0);
        chk("async_rst_commit", 32'(bus.commit),      32'h0);
        chk("async_rst_pc",     bus.perf_commit,      32'h0);
        chk("async_rst_ps",     bus.perf_stall,       32'h0);
        model_reset();
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (5) step(1'b1, '1, 1'b1, 1'b0, '0);
        chk("refill_valid", 32'(bus.stage_valid), 32'h1f);

        // Random traffic, including out-of-range flush indices.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < S; i++) rgv[i] = ($urandom_range(0, 99) < 85);
            step($urandom_range(0, 99) < 75, rgv, $urandom_range(0, 99) < 80,
                 $urandom_range(0, 99) < 10, FSW'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control block for the MIPS core. It tracks a per-stage valid bit for an N-stage in-order pipeline and derives the allowin/handshake chain and the segment-register load enables. It also handles partial flushes from any stage and emits a commit strobe for write-back and debug. It sits beside the segment registers (if_id, id_ex, ex_mem, mem_wb), replacing their hard-wired always-advance behaviour with a stall- and flush-capable chain.

## Interface
Parameters:
- STAGES, 5, number of tracked stages; index 0 is youngest (receives from fetch), STAGES-1 is oldest (write-back); legal 2..8
- FSW, 3, width of flush_stage; must satisfy 2^FSW >= STAGES

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage 0 accepts this cycle
- ready_go  in  STAGES  per-stage "work done, may leave" flag
- out_ready  in  1  downstream (regfile/commit) accepts the oldest stage
- flush_req  in  1  kill request
- flush_stage  in  FSW  oldest stage index to kill; stages 0..flush_stage are cleared
- stage_valid  out  STAGES  registered valid bits
- stage_allowin  out  STAGES  per-stage allowin
- stage_en  out  STAGES  load enable for the segment register feeding stage i
- commit  out  1  oldest stage retires this cycle
- perf_commit  out  32  retired-instruction counter (see Configuration)
- perf_stall  out  32  fetch-stall cycle counter (see Configuration)

## Operation
- allowin[S-1] = !valid[S-1] | (ready_go[S-1] & out_ready); allowin[i] = !valid[i] | (ready_go[i] & allowin[i+1]).
- in_ready = allowin[0] & !flush_req.
- stage_en[0] = in_valid & in_ready; stage_en[i] = allowin[i] & valid[i-1] & ready_go[i-1], for i >= 1.
- Valid update without flush:
  - if allowin[0], valid[0] <= in_valid;
  - for i >= 1, if allowin[i], valid[i] <= valid[i-1] & ready_go[i-1];
  - otherwise each valid bit holds.
- Flush with k = min(flush_stage, STAGES-1):
  - valid[0..k] <= 0 regardless of the normal update;
  - if k < S-1 and allowin[k+1], valid[k+1] <= 0 (the killed instruction is not passed on); otherwise stage k+1 holds;
  - stages > k+1 update normally.
- commit = valid[S-1] & ready_go[S-1] & out_ready & !(flush_req & k == S-1).
- A killed stage never produces stage_en into the next stage. stage_en[k+1] is forced 0 during flush.
- Flush and stall in the same cycle: flush wins for stages 0..k. Older stages stay stalled.

## Timing
- Reset: stage_valid = 0, perf_commit = 0, perf_stall = 0. Combinational outputs follow from this: in_ready = 1, stage_allowin = all 1, commit = 0.
- in_ready, stage_allowin, stage_en and commit are combinational from the current inputs and valid registers. The longest path is the allowin chain through STAGES stages.
- Latency with all ready_go = 1 and out_ready = 1:
  - instruction accepted at edge t is in stage i during cycle t+1+i;
  - commit is asserted in cycle t+STAGES.
- Throughput is one instruction per cycle when unstalled. A stall bubble costs exactly one cycle per stalled cycle.
- Reset mid-operation clears all valid bits asynchronously. No commit is asserted while reset is high.
- Counters wrap modulo 2^32.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - perf_commit increments on every cycle with commit = 1;
  - perf_stall increments on every cycle with in_valid & !in_ready.
- Not defined: both counters are absent; perf_commit and perf_stall are tied to 0.

## Test plan
- STAGES=5, in_valid = 1 continuously, all ready_go = 1, out_ready = 1, first accept at edge 0 -> commit first high in cycle 5 and then every cycle; stage_valid = 5'b11111 from cycle 5.
- Pipeline full, ready_go[2] = 0 for 3 cycles -> stage_allowin[0..2] = 0 and in_ready = 0 for those cycles; stage 3 receives bubbles; no instruction lost or duplicated (sequence-ID scoreboard).
- Pipeline full, flush_req = 1 with flush_stage = 1 for one cycle -> next cycle stage_valid[1:0] = 0, stage_valid[2] = 0 (bubble), stages 3 and 4 advance; in_ready = 0 during the flush cycle.
- flush_req = 1 with flush_stage = 4 while valid[4] & ready_go[4] & out_ready -> commit = 0 that cycle; stage_valid = 0 next cycle.
- out_ready = 0 for 10 cycles with in_valid = 1 -> exactly 5 instructions held, in_ready = 0 after fill; with PIPE_CTRL_PERF_EN, perf_stall increments by 1 per blocked cycle.
- Assert reset mid-stream with stage_valid = 5'b10110 -> stage_valid = 0 immediately (asynchronous), commit = 0, counters = 0; normal fill resumes after deassertion.
